// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the memory-port arbiter.
// Grantee codes, FSM states, IV address and starvation limit.
package cpu_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_D    = 2'd2;
    localparam logic [1:0] GNT_IV   = 2'd3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [7:0] IV_ADDR_DEF      = 8'h01;
    localparam int         STARVE_LIMIT_DEF = 3;

    function automatic logic [1:0] gnt_encode(input logic if_g, input logic d_g, input logic iv_g);
        logic [1:0] code;
        if (iv_g) begin
            code = GNT_IV;
        end else if (d_g) begin
            code = GNT_D;
        end else if (if_g) begin
            code = GNT_IF;
        end else begin
            code = GNT_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Client request/response and single memory-port signals of the arbiter.
// slave = arbiter view, master = clients plus memory.
interface mem_port_arbiter_if;

    logic       if_req;
    logic [7:0] if_addr;
    logic       if_gnt;
    logic       if_valid;
    logic [7:0] if_rdata;

    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_gnt;
    logic       d_valid;
    logic [7:0] d_rdata;

    logic       iv_req;
    logic       iv_gnt;
    logic       iv_valid;
    logic [7:0] iv_rdata;

    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;

    logic       fetch_stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, iv_req, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               iv_gnt, iv_valid, iv_rdata, mem_addr, mem_wdata, mem_we, mem_re,
               fetch_stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, iv_req, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               iv_gnt, iv_valid, iv_rdata, mem_addr, mem_wdata, mem_we, mem_re,
               fetch_stall
    );

endinterface

// File: rtl/mem_prio_sel.sv
// Combinational priority select: iv > d > if, fetch beats d when starved.
// i_en forces all grants low (held in reset).
module mem_prio_sel (
    input  logic i_en,
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_iv_req,
    input  logic i_starved,
    output logic o_if_gnt,
    output logic o_d_gnt,
    output logic o_iv_gnt
);

    assign o_iv_gnt = i_en & i_iv_req;
    assign o_d_gnt  = i_en & ~i_iv_req & i_d_req & ~(i_starved & i_if_req);
    assign o_if_gnt = i_en & ~i_iv_req & i_if_req & (~i_d_req | i_starved);

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-client arbiter for one synchronous-read memory port.
// Grants and command are combinational; valids follow one cycle later.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter logic [7:0] IV_ADDR      = IV_ADDR_DEF,
    parameter int         STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    mem_port_arbiter_if.slave   bus
);

    localparam int                CNT_W   = (STARVE_LIMIT > 3) ? $clog2(STARVE_LIMIT + 1) : 2;
    localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [0:0]       r_state;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_starve;
    logic             r_iv_blk;

    logic       w_iv_ok;
    logic       w_starved;
    logic       w_if_gnt;
    logic       w_d_gnt;
    logic       w_iv_gnt;
    logic       w_any_gnt;
    logic [1:0] w_gnt_code;
    logic       w_live;
    logic       w_if_valid;
    logic       w_d_valid;
    logic       w_iv_valid;

    assign w_iv_ok    = bus.iv_req & ~r_iv_blk;
    assign w_starved  = (r_starve >= LIMIT);
    assign w_any_gnt  = w_if_gnt | w_d_gnt | w_iv_gnt;
    assign w_gnt_code = gnt_encode(w_if_gnt, w_d_gnt, w_iv_gnt);

    mem_prio_sel u_prio_sel (
        .i_en      (rstn),
        .i_if_req  (bus.if_req),
        .i_d_req   (bus.d_req),
        .i_iv_req  (w_iv_ok),
        .i_starved (w_starved),
        .o_if_gnt  (w_if_gnt),
        .o_d_gnt   (w_d_gnt),
        .o_iv_gnt  (w_iv_gnt)
    );

    // Access FSM and the grantee whose valid is due next cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_last  <= GNT_NONE;
        end else begin
            r_last <= w_gnt_code;
            case (r_state)
                ST_IDLE:   r_state <= w_any_gnt ? ST_ACCESS : ST_IDLE;
                ST_ACCESS: r_state <= w_any_gnt ? ST_ACCESS : ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Starvation counter saturates at the limit; fetch progress or no fetch clears it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve <= '0;
        end else if (w_if_gnt || !bus.if_req) begin
            r_starve <= '0;
        end else if ((w_d_gnt || w_iv_gnt) && !w_starved) begin
            r_starve <= r_starve + CNT_ONE;
        end else begin
            r_starve <= r_starve;
        end
    end

    // Single-shot IV: re-arm only after iv_req has been seen low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_iv_blk <= 1'b0;
        end else if (w_iv_gnt) begin
            r_iv_blk <= 1'b1;
        end else if (!bus.iv_req) begin
            r_iv_blk <= 1'b0;
        end else begin
            r_iv_blk <= r_iv_blk;
        end
    end

    // Memory command for the current grant
    always_comb begin
        bus.mem_addr  = 8'h00;
        bus.mem_wdata = 8'h00;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        if (w_iv_gnt) begin
            bus.mem_addr = IV_ADDR;
            bus.mem_re   = 1'b1;
        end else if (w_d_gnt) begin
            bus.mem_addr = bus.d_addr;
            if (bus.d_we) begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.d_wdata;
            end else begin
                bus.mem_re = 1'b1;
            end
        end else if (w_if_gnt) begin
            bus.mem_addr = bus.if_addr;
            bus.mem_re   = 1'b1;
        end else begin
            bus.mem_re = 1'b0;
        end
    end

    assign w_live     = (r_state == ST_ACCESS);
    assign w_if_valid = w_live & (r_last == GNT_IF);
    assign w_d_valid  = w_live & (r_last == GNT_D);
    assign w_iv_valid = w_live & (r_last == GNT_IV);

    assign bus.if_gnt      = w_if_gnt;
    assign bus.d_gnt       = w_d_gnt;
    assign bus.iv_gnt      = w_iv_gnt;
    assign bus.if_valid    = w_if_valid;
    assign bus.d_valid     = w_d_valid;
    assign bus.iv_valid    = w_iv_valid;
    assign bus.if_rdata    = w_if_valid ? bus.mem_rdata : 8'h00;
    assign bus.d_rdata     = w_d_valid  ? bus.mem_rdata : 8'h00;
    assign bus.iv_rdata    = w_iv_valid ? bus.mem_rdata : 8'h00;
    assign bus.fetch_stall = rstn & bus.if_req & ~w_if_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic,
// every cycle compared against a rule-level model of arbitration.
module tb_mem_port_arbiter;

    localparam int LIMIT = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.IV_ADDR(8'h01), .STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        case (a)
            0:       v = 8'h88;
            1:       v = 8'h89;
            2:       v = 8'h24;
            5:       v = 8'h88;
            255:     v = 8'h71;
            default: v = 8'(a) ^ 8'h5A;
        endcase
        return v;
    endfunction

    // Environment memory: loaded on first edge, synchronous read, zero when idle
    logic [7:0] mem [256];
    bit         mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
            bus.mem_rdata <= 8'h00;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr] : 8'h00;
        end
    end

    // Reference model state
    logic [7:0] shadow [256];
    int         m_starve = 0;
    bit         m_blk    = 1'b0;
    int         m_pend   = 0;
    logic [7:0] m_pdata  = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, predict from the rules, compare, advance the model
    task automatic step(input bit rst, input bit ifr, input logic [7:0] ia,
                        input bit dr, input bit dw, input logic [7:0] da,
                        input logic [7:0] dwd, input bit ivr);
        int         win;
        logic [7:0] e_addr;
        logic [7:0] e_wd;
        bit         e_we;
        bit         e_re;
        logic [2:0] e_g;
        logic [2:0] e_val;
        logic [23:0] e_rd;
        @(posedge clk);
        #1;
        rstn        = !rst;
        bus.if_req  = ifr;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.iv_req  = ivr;
        #1;
        if (rst) begin
            m_starve = 0;
            m_blk    = 1'b0;
            m_pend   = 0;
            win      = 0;
        end else if (ivr && !m_blk) begin
            win = 3;
        end else if (dr && !(ifr && m_starve >= LIMIT)) begin
            win = 2;
        end else if (ifr) begin
            win = 1;
        end else begin
            win = 0;
        end

        e_addr = 8'h00; e_wd = 8'h00; e_we = 1'b0; e_re = 1'b0; e_g = 3'b000;
        case (win)
            1: begin e_g = 3'b100; e_addr = ia;    e_re = 1'b1; end
            2: begin e_g = 3'b010; e_addr = da;
                     if (dw) begin e_we = 1'b1; e_wd = dwd; end else e_re = 1'b1; end
            3: begin e_g = 3'b001; e_addr = 8'h01; e_re = 1'b1; end
            default: e_g = 3'b000;
        endcase
        e_val = 3'b000; e_rd = 24'h0;
        case (m_pend)
            1: begin e_val = 3'b100; e_rd[23:16] = m_pdata; end
            2: begin e_val = 3'b010; e_rd[15:8]  = m_pdata; end
            3: begin e_val = 3'b001; e_rd[7:0]   = m_pdata; end
            default: e_val = 3'b000;
        endcase

        check_val("gnt", {29'd0, bus.if_gnt, bus.d_gnt, bus.iv_gnt}, {29'd0, e_g});
        check_val("mem_cmd", {14'd0, bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re},
                  {14'd0, e_addr, e_wd, e_we, e_re});
        check_val("stall", {31'd0, bus.fetch_stall}, {31'd0, (!rst && ifr && win != 1)});
        check_val("valid", {29'd0, bus.if_valid, bus.d_valid, bus.iv_valid}, {29'd0, e_val});
        check_val("rdata", {8'd0, bus.if_rdata, bus.d_rdata, bus.iv_rdata}, {8'd0, e_rd});

        if (!rst) begin
            m_pend  = win;
            m_pdata = (win == 0 || e_we) ? 8'h00 : shadow[e_addr];
            if (e_we) shadow[da] = dwd;
            if (win == 1 || !ifr) m_starve = 0;
            else if (win >= 2 && m_starve < LIMIT) m_starve++;
            if (win == 3) m_blk = 1'b1;
            else if (!ivr) m_blk = 1'b0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        bit iv_lvl;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        bus.if_req = 1'b0; bus.if_addr = 8'h00; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = 8'h00; bus.d_wdata = 8'h00; bus.iv_req = 1'b0;

        // Reset with every request asserted: all outputs stay zero
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 8'h10, 8'hAA, 1'b1);

        // Fetch from 05 in the first cycle after release
        step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_val("r030_gnt", {31'd0, bus.if_gnt}, 32'd1);
        idle();
        check_val("r030_valid", {31'd0, bus.if_valid}, 32'd1);
        check_val("r030_data", {24'd0, bus.if_rdata}, 32'h88);

        // Fetch vs data read of FF: d three times, then fetch
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
            if (c < 4) begin
                check_val("r031_dgnt", {31'd0, bus.d_gnt}, 32'd1);
                check_val("r031_stall", {31'd0, bus.fetch_stall}, 32'd1);
            end else begin
                check_val("r031_ifgnt", {31'd0, bus.if_gnt}, 32'd1);
            end
            if (c == 2) check_val("r031_drdata", {24'd0, bus.d_rdata}, 32'h71);
        end
        idle();

        // IV wins over all, then blocked while held
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1);
        check_val("r032_ivgnt", {31'd0, bus.iv_gnt}, 32'd1);
        check_val("r032_addr", {24'd0, bus.mem_addr}, 32'h01);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1);
        check_val("r032_noiv", {31'd0, bus.iv_gnt}, 32'd0);
        check_val("r032_dgnt", {31'd0, bus.d_gnt}, 32'd1);
        idle();

        // Data write FE <= 24
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 8'h24, 1'b0);
        check_val("r033_we", {31'd0, bus.mem_we}, 32'd1);
        idle();
        check_val("r033_dvalid", {31'd0, bus.d_valid}, 32'd1);
        check_val("r033_we_off", {31'd0, bus.mem_we}, 32'd0);
        idle();
        check_val("r033_mem", {24'd0, mem[254]}, 32'h24);

        // Back-to-back fetches 0,1,2
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_val("r035_d0", {23'd0, bus.if_valid, bus.if_rdata}, {23'd0, 1'b1, 8'h88});
        step(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_val("r035_d1", {23'd0, bus.if_valid, bus.if_rdata}, {23'd0, 1'b1, 8'h89});
        idle();
        check_val("r035_d2", {23'd0, bus.if_valid, bus.if_rdata}, {23'd0, 1'b1, 8'h24});

        // Reset right after a grant (starve count nonzero): no valid, counter cleared
        step(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b1);
        check_val("r034_novalid", {31'd0, bus.d_valid}, 32'd0);
        step(1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b0);
            if (c == 1) check_val("r034_novalid_rel", {29'd0, bus.if_valid, bus.d_valid, bus.iv_valid}, 32'd0);
            if (c == 3) check_val("r034_starve_d", {31'd0, bus.d_gnt}, 32'd1);
        end
        idle();

        // Random traffic
        iv_lvl = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) iv_lvl = ~iv_lvl;
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 65, 8'($urandom),
                 $urandom_range(0, 99) < 55, 1'($urandom), 8'($urandom), 8'($urandom),
                 iv_lvl);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter IV_ADDR, default 8'h01: memory address read for the interrupt-vector request.
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive non-fetch grants allowed while fetch is waiting.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1, if_addr  in  8: instruction-fetch read request and address.
REQ-006 if_gnt  out  1, if_valid  out  1, if_rdata  out  8: fetch grant, data-valid strobe, read data.
REQ-007 d_req  in  1, d_we  in  1, d_addr  in  8, d_wdata  in  8: data-port request (LDD/STD/PUSH/POP).
REQ-008 d_gnt  out  1, d_valid  out  1, d_rdata  out  8: data grant, completion strobe (reads and writes), read data.
REQ-009 iv_req  in  1, iv_gnt  out  1, iv_valid  out  1, iv_rdata  out  8: interrupt-vector fetch from IV_ADDR.
REQ-010 mem_addr  out  8, mem_wdata  out  8, mem_we  out  1, mem_re  out  1: single memory port command.
REQ-011 mem_rdata  in  8: synchronous-read data, valid the cycle after mem_re.
REQ-012 fetch_stall  out  1: high when if_req is high and if_gnt is low.

Function
REQ-013 At most one of if_gnt, d_gnt, iv_gnt SHALL be high in any cycle.
REQ-014 Grants SHALL be combinational from current requests and registered state; the granted command SHALL be driven on mem_* in the same cycle.
REQ-015 Priority SHALL be iv > d > if, except starvation override (REQ-018).
REQ-016 Grant cycle N -> matching *_valid high exactly in cycle N+1 for one cycle; *_rdata = mem_rdata in that cycle, 8'h00 otherwise.
REQ-017 A new grant SHALL be issuable in the cycle a previous valid is asserted (throughput one access per cycle).
REQ-018 starve_cnt (2 bits min): increments on each iv/d grant while if_req is high; clears on if grant or if_req low; at STARVE_LIMIT fetch SHALL win over d (not over iv).
REQ-019 iv_req SHALL be single-shot: after iv grant, further iv grants blocked until iv_req observed low for at least one cycle.
REQ-020 Write grant: mem_we=1, mem_re=0; read grant: mem_re=1, mem_we=0; no grant: both 0, mem_addr/mem_wdata = 8'h00.
REQ-021 Request dropped before grant SHALL produce no memory access and no valid.
REQ-022 FSM states IDLE (no access in flight), ACCESS (valid due next cycle); IDLE->ACCESS on any grant; ACCESS->ACCESS on grant, ->IDLE otherwise.
REQ-023 Registered "last grantee" (none/if/d/iv) SHALL select which *_valid fires.

Reset
REQ-024 rstn low SHALL immediately force FSM=IDLE, starve_cnt=0, iv block cleared, last grantee=none.
REQ-025 During reset all outputs SHALL be 0 (grants, valids, rdata, mem_*, fetch_stall), regardless of requests.
REQ-026 An access in flight at reset assertion SHALL produce no valid after reset release.
REQ-027 First grant possible in the first rising edge cycle after rstn deasserts.

Structure
REQ-028 Shared package cpu_pkg SHALL hold grantee encoding (GNT_NONE/IF/D/IV), FSM state encoding, IV_ADDR and STARVE_LIMIT defaults.
REQ-029 One sub-module, mem_prio_sel: combinational priority select with starvation input; all state in top.

Verification
REQ-030 if_req only, if_addr=8'h05, mem[5]=8'h88 -> if_gnt same cycle, if_valid next cycle, if_rdata=8'h88.
REQ-031 if_req and d_req (read 8'hFF, mem=8'h71) held together -> d wins 3 cycles, cycle 4 if_gnt, fetch_stall high cycles 1-3.
REQ-032 iv_req, d_req, if_req together -> iv_gnt, mem_addr=8'h01; iv_req held -> no second iv grant; d granted next cycle.
REQ-033 d_req write d_addr=8'hFE, d_wdata=8'h24 -> mem_we=1 one cycle, d_valid next cycle, mem[FE]=8'h24.
REQ-034 rstn low in cycle after grant -> no valid ever appears, all outputs 0, starve_cnt 0 after release.
REQ-035 Back-to-back if reads 0,1,2 -> valids in consecutive cycles, data 8'h88, 8'h89, 8'h24.
